ulpi_reg_arbiter: RTL

Round-robin arbiter and sequencer that shares the single ULPI register-access port (REG_EN/REG_RW/REG_ADDR/REG_DATA_I, with REG_DONE/REG_FAIL back) among N_REQ independent requesters. Typical requesters are PHY init, link-state polling and debug/scratch access. It sits between those clients and the ULPI block, in the CLK_60M domain. It serialises register transactions, retries failed ones and returns read data with a per-requester completion pulse.

---
 rtl/ulpi_reg_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/ulpi_reg_arbiter.sv
// ulpi_reg_arbiter
// Round-robin arbiter and sequencer sharing the single ULPI register-access
// port among N_REQ requesters. Serialises transactions, retries failures up
// to MAX_RETRY times and returns read data with a per-requester ACK/ERR pulse.
//
// Ports:
//   CLK_60M, NRST_A_USB          60 MHz ULPI clock, async active-low reset
//   READY                        ULPI block can accept a register command
//   REQ, REQ_RW                  per-requester request / direction (1 = write)
//   REQ_ADDR, REQ_DATA           packed 6-bit addresses / 8-bit write data
//   GNT, ACK, ERR                one-hot grant, success pulse, error pulse
//   RD_DATA                      last read result
//   REG_EN, REG_RW, REG_ADDR,
//   REG_DATA_I                   command to the ULPI block
//   REG_DATA_O, REG_DONE,
//   REG_FAIL                     response from the ULPI block
//
// Optional feature: define ULPI_ARB_TIMEOUT_EN to build a WAIT-state timer
// that treats TIMEOUT_CYC silent WAIT cycles like REG_FAIL.
//
// state | meaning
// IDLE  | arbitrate from ptr, latch winner's fields
// ISSUE | REG_EN high, hold until READY
// WAIT  | wait for REG_DONE / REG_FAIL (or timeout)
// DONE  | one-cycle ACK/ERR pulse, advance ptr, drop GNT

module ulpi_reg_arbiter #(
  parameter int N_REQ       = 3,
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic                 CLK_60M,
  input  logic                 NRST_A_USB,
  input  logic                 READY,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [N_REQ-1:0]     REQ_RW,
  input  logic [6*N_REQ-1:0]   REQ_ADDR,
  input  logic [8*N_REQ-1:0]   REQ_DATA,
  output logic [N_REQ-1:0]     GNT,
  output logic [N_REQ-1:0]     ACK,
  output logic [N_REQ-1:0]     ERR,
  output logic [7:0]           RD_DATA,
  output logic                 REG_EN,
  output logic                 REG_RW,
  output logic [5:0]           REG_ADDR,
  output logic [7:0]           REG_DATA_I,
  input  logic [7:0]           REG_DATA_O,
  input  logic                 REG_DONE,
  input  logic                 REG_FAIL
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] g_idx;
  logic [2:0]    retry_cnt;
  logic          lat_rw;
  logic [5:0]    lat_addr;
  logic [7:0]    lat_data;

  logic [PW-1:0] sel_idx;
  logic          sel_vld;
  logic          sel_rw;
  logic [5:0]    sel_addr;
  logic [7:0]    sel_data;
  logic          timeout;

  // Cyclic search from ptr: walking k downwards leaves the nearest hit last.
  always_comb begin
    int idx;
    idx      = 0;
    sel_vld  = 1'b0;
    sel_idx  = '0;
    sel_rw   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (REQ[idx[PW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = idx[PW-1:0];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_rw   = REQ_RW[i];
        sel_addr = REQ_ADDR[6*i +: 6];
        sel_data = REQ_DATA[8*i +: 8];
      end
    end
  end

`ifdef ULPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wait_cyc;

  // Held at zero outside WAIT, so every entry into WAIT starts a fresh count.
  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB)          wait_cyc <= '0;
    else if (state != S_WAIT) wait_cyc <= '0;
    else                      wait_cyc <= wait_cyc + TW'(1);
  end

  // Fires on the TIMEOUT_CYC-th WAIT cycle.
  assign timeout = (state == S_WAIT) && (wait_cyc == TW'(TIMEOUT_CYC - 1));
`else
  // No timer in this build; the comparison is constant false.
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge CLK_60M or negedge NRST_A_USB) begin
    if (!NRST_A_USB) begin
      state      <= S_IDLE;
      ptr        <= '0;
      g_idx      <= '0;
      retry_cnt  <= '0;
      lat_rw     <= 1'b0;
      lat_addr   <= '0;
      lat_data   <= '0;
      GNT        <= '0;
      ACK        <= '0;
      ERR        <= '0;
      RD_DATA    <= '0;
      REG_EN     <= 1'b0;
      REG_RW     <= 1'b0;
      REG_ADDR   <= '0;
      REG_DATA_I <= '0;
    end else begin
      ACK <= '0;
      ERR <= '0;
      case (state)
        S_IDLE: begin
          if (sel_vld) begin
            g_idx      <= sel_idx;
            GNT        <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
            lat_rw     <= sel_rw;
            lat_addr   <= sel_addr;
            lat_data   <= sel_data;
            retry_cnt  <= '0;
            REG_EN     <= 1'b1;
            REG_RW     <= sel_rw;
            REG_ADDR   <= sel_addr;
            REG_DATA_I <= sel_data;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (READY) begin
            REG_EN     <= 1'b0;
            REG_RW     <= 1'b0;
            REG_ADDR   <= '0;
            REG_DATA_I <= '0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A real response beats both failure and timeout.
          if (REG_DONE) begin
            ACK   <= GNT;
            if (!lat_rw) RD_DATA <= REG_DATA_O;
            state <= S_DONE;
          end else if (REG_FAIL || timeout) begin
            if (retry_cnt < 3'(MAX_RETRY)) begin
              retry_cnt  <= retry_cnt + 3'd1;
              REG_EN     <= 1'b1;
              REG_RW     <= lat_rw;
              REG_ADDR   <= lat_addr;
              REG_DATA_I <= lat_data;
              state      <= S_ISSUE;
            end else begin
              ERR   <= GNT;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          GNT   <= '0;
          ptr   <= (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + PW'(1);
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
